// File: rtl/gtr_pkg.sv
// gtr_pkg: shared FSM state type, one-hot mode constants and mode validation for power_mode_ctrl.
package gtr_pkg;
  typedef enum logic [1:0] {OFF, ARMING, ON, WAIT_REL} state_t;
  localparam logic [2:0] MODE_NONE   = 3'b000;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_SEMI   = 3'b010;
  localparam logic [2:0] MODE_AUTO   = 3'b100;
  function automatic logic [2:0] mode_decode(input logic [2:0] m);
    return (m == MODE_MANUAL || m == MODE_SEMI || m == MODE_AUTO) ? m : MODE_NONE;
  endfunction
endpackage

// File: rtl/power_mode_ctrl_tick.sv
// tick_gen: one-cycle tick every CLK_HZ/TICK_HZ clocks.
//   i_clk   in  system clock
//   i_rst_n in  synchronous active-low reset
//   o_tick  out tick pulse
module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int W   = $clog2(DIV) + 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= (r_cnt == W'(DIV - 1)) ? '0 : r_cnt + W'(1);
  assign o_tick = r_cnt == W'(DIV - 1);
endmodule

// File: rtl/power_mode_ctrl.sv
// power_mode_ctrl: hold-to-start power FSM with debounced one-hot mode enables.
//   sys_clk, rst_n (sync, active-low)
//   power_on, power_off, mode_signal[2:0]  raw asynchronous inputs
//   kill_req                               sys_clk-domain power kill
//   power_active, power_on_led             engine on
//   mode_led[2:0], manual_en/semi_en/auto_en  accepted mode while on
//   mode_changed                           one-cycle pulse on accepted-mode change in ON
// Optional: POWER_MODE_AUTO_OFF_EN builds the idle auto-off counter.
module power_mode_ctrl import gtr_pkg::*; #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int HOLD_MS = 1000,
  parameter int DEB_MS  = 20,
  parameter int IDLE_MS = 10000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       kill_req,
  input  logic [2:0] mode_signal,
  output logic       power_active,
  output logic       power_on_led,
  output logic [2:0] mode_led,
  output logic       manual_en,
  output logic       semi_en,
  output logic       auto_en,
  output logic       mode_changed
);
  localparam int HW = $clog2(HOLD_MS) + 1;
  localparam int DW = $clog2(DEB_MS) + 1;
  state_t r_state, w_next;
  logic r_on_m, r_on_s, r_off_m, r_off_s, r_mode_changed, w_tick, w_idle_done;
  logic [2:0] r_mode_m, r_mode_s, r_cand, r_acc, w_acc_next;
  logic [HW-1:0] r_hold;
  logic [DW-1:0] r_stab;
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .i_clk(sys_clk), .i_rst_n(rst_n), .o_tick(w_tick)
  );
  // Accept the candidate on the tick that completes its DEB_MS-tick stable window.
  assign w_acc_next = (r_mode_s == r_cand && w_tick && r_stab == DW'(DEB_MS - 1)) ?
                      mode_decode(r_cand) : r_acc;
  always_ff @(posedge sys_clk)
    if (!rst_n) r_state <= OFF;
    else        r_state <= w_next;
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      {r_on_m, r_on_s, r_off_m, r_off_s} <= '0;
      r_mode_m       <= MODE_NONE;
      r_mode_s       <= MODE_NONE;
      r_cand         <= MODE_NONE;
      r_acc          <= MODE_NONE;
      r_stab         <= '0;
      r_hold         <= '0;
      r_mode_changed <= 1'b0;
    end else begin
      r_on_m         <= power_on;
      r_on_s         <= r_on_m;
      r_off_m        <= power_off;
      r_off_s        <= r_off_m;
      r_mode_m       <= mode_signal;
      r_mode_s       <= r_mode_m;
      r_cand         <= r_mode_s;
      r_stab         <= (r_mode_s != r_cand) ? '0 :
                        (w_tick && r_stab != DW'(DEB_MS)) ? r_stab + DW'(1) : r_stab;
      r_acc          <= w_acc_next;
      r_hold         <= (r_state != ARMING) ? '0 :
                        (w_tick && r_hold != HW'(HOLD_MS)) ? r_hold + HW'(1) : r_hold;
      // Entering ON compares against "none", so a settled mode announces itself once.
      r_mode_changed <= (w_next == ON) && (w_acc_next != ((r_state == ON) ? r_acc : MODE_NONE));
    end
`ifdef POWER_MODE_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_MS) + 1;
  logic [IW-1:0] r_idle;
  always_ff @(posedge sys_clk)
    if (!rst_n || r_state != ON || r_acc != MODE_NONE) r_idle <= '0;
    else if (w_tick && r_idle != IW'(IDLE_MS))           r_idle <= r_idle + IW'(1);
  assign w_idle_done = (r_state == ON) && (r_idle == IW'(IDLE_MS));
`else
  // Idle window is positive, so ON never times out in this build.
  assign w_idle_done = IDLE_MS < 0;
`endif
  // Priority: power_off_s > kill_req > power_on_s.
  always_comb begin
    w_next = r_state;
    case (r_state)
      OFF:      if (r_on_s && !r_off_s && !kill_req) w_next = ARMING;
      ARMING:   if (r_off_s || kill_req || !r_on_s) w_next = OFF;
                else if (r_hold == HW'(HOLD_MS))   w_next = ON;
      ON:       if (r_off_s || kill_req) w_next = WAIT_REL;
                else if (w_idle_done)    w_next = (r_on_s || r_off_s) ? WAIT_REL : OFF;
      WAIT_REL: if (!r_on_s && !r_off_s) w_next = OFF;
      default:  w_next = OFF;
    endcase
  end
  always_comb begin
    power_active = r_state == ON;
    power_on_led = power_active;
    mode_led     = power_active ? r_acc : MODE_NONE;
    {auto_en, semi_en, manual_en} = mode_led;
    mode_changed = r_mode_changed;
  end
endmodule

// File: tb/tb_power_mode_ctrl.sv
// tb_power_mode_ctrl: scenario and randomized checks of power_mode_ctrl against a timestamp-based reference model.
module tb_power_mode_ctrl;
  import gtr_pkg::*;
  localparam int HOLD_MS = 5, DEB_MS = 2, IDLE_MS = 8, DIV = 10;
  logic sys_clk = 1'b0, rst_n = 1'b0, power_on = 1'b0, power_off = 1'b0, kill_req = 1'b0;
  logic [2:0] mode_signal = 3'b000;
  logic power_active, power_on_led, manual_en, semi_en, auto_en, mode_changed;
  logic [2:0] mode_led;
  int tests = 0, fails = 0;
  always #5 sys_clk = ~sys_clk;
  power_mode_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .HOLD_MS(HOLD_MS), .DEB_MS(DEB_MS), .IDLE_MS(IDLE_MS)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .power_on(power_on), .power_off(power_off),
    .kill_req(kill_req), .mode_signal(mode_signal), .power_active(power_active),
    .power_on_led(power_on_led), .mode_led(mode_led), .manual_en(manual_en),
    .semi_en(semi_en), .auto_en(auto_en), .mode_changed(mode_changed)
  );
  // Reference model: edges counted from reset release, ticks land on every DIV-th edge,
  // durations measured as tick counts between timestamps.
  typedef enum int {M_OFF, M_ARM, M_ON, M_WAIT} mst_t;
  mst_t m_st = M_OFF;
  int e = 0, arm_e = 0, chg_e = 0, idle_e = -1;
  logic m_on_d1 = 0, m_on_d2 = 0, m_off_d1 = 0, m_off_d2 = 0, m_mc = 0;
  logic [2:0] m_md1 = 0, m_md2 = 0, m_ms = 0, m_acc = 0;
  function automatic int ticks(int a, int b);
    return b / DIV - a / DIV;
  endfunction
  function automatic logic [2:0] dec(logic [2:0] m);
    return ($countones(m) == 1) ? m : 3'b000;
  endfunction
  task automatic model_edge();
    logic on_s, off_s;
    logic [2:0] ms, prev_acc;
    mst_t prev_st;
    if (!rst_n) begin
      e = 0; m_st = M_OFF; arm_e = 0; chg_e = 0; idle_e = -1;
      {m_on_d1, m_on_d2, m_off_d1, m_off_d2, m_mc} = '0;
      m_md1 = 0; m_md2 = 0; m_ms = 0; m_acc = 0;
      return;
    end
    e++;
    on_s = m_on_d2; off_s = m_off_d2; ms = m_md2;
    m_on_d2 = m_on_d1; m_on_d1 = power_on;
    m_off_d2 = m_off_d1; m_off_d1 = power_off;
    m_md2 = m_md1; m_md1 = mode_signal;
    prev_st = m_st; prev_acc = m_acc;
    if (ms != m_ms) begin m_ms = ms; chg_e = e; end
    if (ticks(chg_e, e) >= DEB_MS) m_acc = dec(m_ms);
    case (prev_st)
      M_OFF:  if (on_s && !off_s && !kill_req) begin m_st = M_ARM; arm_e = e; end
      M_ARM:  begin
        if (off_s || kill_req || !on_s) m_st = M_OFF;
        else if (ticks(arm_e, e - 1) >= HOLD_MS) m_st = M_ON;
      end
      M_ON:   begin
        if (off_s || kill_req) m_st = M_WAIT;
`ifdef POWER_MODE_AUTO_OFF_EN
        else if (idle_e >= 0 && ticks(idle_e, e - 1) >= IDLE_MS) m_st = (on_s || off_s) ? M_WAIT : M_OFF;
`endif
      end
      default: if (!on_s && !off_s) m_st = M_OFF;
    endcase
    if (m_st == M_ON && m_acc == 3'b000) begin
      if (idle_e < 0) idle_e = e;
    end else idle_e = -1;
    m_mc = (m_st == M_ON) && (m_acc != ((prev_st == M_ON) ? prev_acc : 3'b000));
  endtask
  function automatic logic [8:0] exp_v();
    logic on_b;
    logic [2:0] l;
    on_b = m_st == M_ON;
    l = on_b ? m_acc : 3'b000;
    return {on_b, on_b, l, l[0], l[1], l[2], m_mc};
  endfunction
  function automatic logic [8:0] got_v();
    return {power_active, power_on_led, mode_led, manual_en, semi_en, auto_en, mode_changed};
  endfunction
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask
  task automatic go_on(input logic [2:0] m);
    mode_signal = m; power_on = 0; power_off = 0; kill_req = 0;
    do_reset();
    power_on = 1;
    repeat (60) step();
  endtask
  task automatic test_reset();
    power_on = 1; power_off = 1; kill_req = 1; mode_signal = 3'b111;
    rst_n = 1'b0;
    repeat (3) step();
    tests++; if (got_v() !== 9'b0) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", got_v(), 9'b0); end
    tests++; if (dut.r_state !== OFF) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, OFF); end
    rst_n = 1'b1; power_off = 0; kill_req = 0; mode_signal = 3'b001;
    for (int i = 0; i < 55; i++) begin
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL reset_release e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
      if (i < 48) begin
        tests++; if (power_active !== 1'b0) begin fails++; $display("FAIL early_on e=%0d got=%b exp=0", e, power_active); end
      end
    end
  endtask
  task automatic test_power_on();
    int pulses, first_on;
    pulses = 0; first_on = -1;
    mode_signal = 3'b001; power_on = 0; power_off = 0; kill_req = 0;
    do_reset();
    power_on = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL power_on e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
      if (mode_changed === 1'b1) pulses++;
      if (power_active === 1'b1 && first_on < 0) first_on = e;
    end
    tests++; if (first_on < 45 || first_on > 60) begin fails++; $display("FAIL on_latency got=%0d exp=45..60", first_on); end
    tests++; if ({power_active, manual_en, mode_led} !== 5'b11001) begin fails++; $display("FAIL on_manual got=%b exp=11001", {power_active, manual_en, mode_led}); end
    tests++; if (pulses != 1) begin fails++; $display("FAIL mc_pulses got=%0d exp=1", pulses); end
  endtask
  task automatic test_short_press();
    mode_signal = 3'b001; power_on = 0; power_off = 0; kill_req = 0;
    do_reset();
    power_on = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 30) power_on = 0;
      step();
      tests++; if (got_v() !== exp_v() || power_active !== 1'b0) begin fails++; $display("FAIL short_press e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
    end
    tests++; if (dut.r_state !== OFF) begin fails++; $display("FAIL short_state got=%0d exp=%0d", dut.r_state, OFF); end
  endtask
  task automatic test_glitch();
    go_on(3'b001);
    power_on = 0;
    for (int i = 0; i < 65; i++) begin
      mode_signal = (i < 5) ? 3'b001 : (i < 15) ? 3'b010 : (i < 25) ? 3'b001 : 3'b010;
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL glitch e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
      if (i < 30) begin
        tests++; if (manual_en !== 1'b1) begin fails++; $display("FAIL glitch_hold e=%0d got=%b exp=1", e, manual_en); end
      end
      tests++; if (manual_en === 1'b1 && semi_en === 1'b1) begin fails++; $display("FAIL one_hot e=%0d got=%b exp=single", e, mode_led); end
    end
    tests++; if ({semi_en, manual_en} !== 2'b10) begin fails++; $display("FAIL glitch_end got=%b exp=10", {semi_en, manual_en}); end
  endtask
  task automatic test_kill();
    go_on(3'b100);
    kill_req = 1;
    step();
    kill_req = 0;
    tests++; if (power_active !== 1'b0 || got_v() !== exp_v()) begin fails++; $display("FAIL kill got=%b exp=%b", got_v(), exp_v()); end
    for (int i = 0; i < 80; i++) begin
      step();
      tests++; if (power_active !== 1'b0 || got_v() !== exp_v()) begin fails++; $display("FAIL kill_hold e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
    end
    power_on = 0;
    repeat (5) step();
    power_on = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL rearm e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
    end
    tests++; if ({power_active, auto_en} !== 2'b11) begin fails++; $display("FAIL rearm_on got=%b exp=11", {power_active, auto_en}); end
  endtask
  task automatic test_power_off();
    go_on(3'b010);
    power_on = 0;
    repeat (3) step();
    power_off = 1;
    step(); step();
    tests++; if (power_active !== 1'b1) begin fails++; $display("FAIL off_early got=%b exp=1", power_active); end
    step();
    tests++; if (power_active !== 1'b0 || got_v() !== exp_v()) begin fails++; $display("FAIL off_latency got=%b exp=%b", got_v(), exp_v()); end
    power_off = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL off_release e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
    end
  endtask
  task automatic test_idle();
    int drop;
    drop = -1;
    go_on(3'b011);
    power_on = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      tests++; if (got_v() !== exp_v() || {manual_en, semi_en, auto_en} !== 3'b000) begin fails++; $display("FAIL idle e=%0d got=%b exp=%b", e, got_v(), exp_v()); end
      if (power_active !== 1'b1 && drop < 0) drop = i;
    end
`ifdef POWER_MODE_AUTO_OFF_EN
    tests++; if (drop < 60 || drop > 90) begin fails++; $display("FAIL idle_drop got=%0d exp=60..90", drop); end
`else
    tests++; if (drop != -1) begin fails++; $display("FAIL idle_persist got=%0d exp=-1", drop); end
`endif
  endtask
  task automatic test_random();
    power_on = 0; power_off = 0; kill_req = 0; mode_signal = 3'b001;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) power_on = ~power_on;
      if (power_off ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 149) == 0)) power_off = ~power_off;
      kill_req = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 29) == 0) mode_signal = 3'($urandom_range(0, 7));
      rst_n = $urandom_range(0, 999) != 0;
      step();
      tests++; if (got_v() !== exp_v()) begin fails++; $display("FAIL random i=%0d got=%b exp=%b", i, got_v(), exp_v()); end
    end
    rst_n = 1;
  endtask
  initial begin
    test_reset();
    test_power_on();
    test_short_press();
    test_glitch();
    test_kill();
    test_power_off();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
